// File: rtl/idex_fwd_reg.sv
// ID/EX pipeline register. It also registers the EX operand-forwarding selects and detects load-use stalls.
// Optional performance counters are built only when IDEX_PERF_CNT_EN is defined.
module idex_fwd_reg #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           Valid_ID,
  input  logic [DW-1:0]  Reg1_ID,
  input  logic [DW-1:0]  Reg2_ID,
  input  logic [DW-1:0]  Imm_ID,
  input  logic [RW-1:0]  Rs1_ID,
  input  logic [RW-1:0]  Rs2_ID,
  input  logic [RW-1:0]  Rd_ID,
  input  logic           UsesRs2_ID,
  input  logic           RegWrite_ID,
  input  logic           MemRead_ID,
  input  logic           MemWrite_ID,
  input  logic           ALUSrc_ID,
  input  logic [OPW-1:0] ALUOp_ID,
  input  logic [RW-1:0]  Rd_EXM,
  input  logic           RegWrite_EXM,
  input  logic           Flush_EX,
  input  logic           Hold,
  output logic [DW-1:0]  Reg1_IDEX,
  output logic [DW-1:0]  Reg2_IDEX,
  output logic [DW-1:0]  Imm_IDEX,
  output logic [RW-1:0]  Rs1_IDEX,
  output logic [RW-1:0]  Rs2_IDEX,
  output logic [RW-1:0]  Rd_IDEX,
  output logic           RegWrite_IDEX,
  output logic           MemRead_IDEX,
  output logic           MemWrite_IDEX,
  output logic           ALUSrc_IDEX,
  output logic           Valid_IDEX,
  output logic [OPW-1:0] ALUOp_IDEX,
  output logic [1:0]     ForwardA,
  output logic [1:0]     ForwardB,
  output logic           Stall_ID,
  output logic [31:0]    BubbleCount,
  output logic [31:0]    FwdCount
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  typedef struct packed {
    logic           valid;
    logic [DW-1:0]  reg1;
    logic [DW-1:0]  reg2;
    logic [DW-1:0]  imm;
    logic [RW-1:0]  rs1;
    logic [RW-1:0]  rs2;
    logic [RW-1:0]  rd;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
    logic           alu_src;
    logic [OPW-1:0] alu_op;
    logic [1:0]     fwd_a;
    logic [1:0]     fwd_b;
  } idex_t;

  idex_t q;
  idex_t id_word;

  logic       ex_writes;
  logic       exm_writes;
  logic       hit_ex_a, hit_ex_b;
  logic       hit_m_a, hit_m_b;
  logic [1:0] sel_a, sel_b;
  logic       load_use;
  logic       load_id;

  // Producers that can forward: the instruction now in EX and the one in EX/MEM.
  assign ex_writes  = q.valid & q.reg_write & (q.rd != '0);
  assign exm_writes = RegWrite_EXM & (Rd_EXM != '0);

  assign hit_ex_a = ex_writes & (q.rd == Rs1_ID);
  assign hit_ex_b = ex_writes & UsesRs2_ID & (q.rd == Rs2_ID);
  assign hit_m_a  = exm_writes & (Rd_EXM == Rs1_ID);
  assign hit_m_b  = exm_writes & UsesRs2_ID & (Rd_EXM == Rs2_ID);

  // The EX instruction is the youngest producer, so it beats EX/MEM. A load in EX has no result yet.
  assign sel_a = (hit_ex_a && !q.mem_read) ? SEL_EXM :
                 hit_m_a                   ? SEL_WB  : SEL_REG;
  assign sel_b = (hit_ex_b && !q.mem_read) ? SEL_EXM :
                 hit_m_b                   ? SEL_WB  : SEL_REG;

  assign load_use = Valid_ID & q.valid & q.mem_read & (q.rd != '0) &
                    ((q.rd == Rs1_ID) | (UsesRs2_ID & (q.rd == Rs2_ID)));
  assign Stall_ID = load_use & ~Hold;

  // High on edges that capture a real instruction from ID.
  assign load_id = ~Flush_EX & ~Hold & ~Stall_ID & Valid_ID;

  assign id_word = '{
    valid:     1'b1,
    reg1:      Reg1_ID,
    reg2:      Reg2_ID,
    imm:       Imm_ID,
    rs1:       Rs1_ID,
    rs2:       Rs2_ID,
    rd:        Rd_ID,
    reg_write: RegWrite_ID,
    mem_read:  MemRead_ID,
    mem_write: MemWrite_ID,
    alu_src:   ALUSrc_ID,
    alu_op:    ALUOp_ID,
    fwd_a:     sel_a,
    fwd_b:     sel_b
  };

  // NOTE: reset is sampled on the clock edge and every state update uses <=, so
  // downstream flops read the old value of q within the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (Flush_EX) begin
      q <= '0;
    end else if (Hold) begin
      q <= q;
    end else if (load_id) begin
      q <= id_word;
    end else begin
      // Load-use stall or empty ID slot: insert a bubble.
      q <= '0;
    end
  end

  assign Valid_IDEX    = q.valid;
  assign Reg1_IDEX     = q.reg1;
  assign Reg2_IDEX     = q.reg2;
  assign Imm_IDEX      = q.imm;
  assign Rs1_IDEX      = q.rs1;
  assign Rs2_IDEX      = q.rs2;
  assign Rd_IDEX       = q.rd;
  assign RegWrite_IDEX = q.reg_write;
  assign MemRead_IDEX  = q.mem_read;
  assign MemWrite_IDEX = q.mem_write;
  assign ALUSrc_IDEX   = q.alu_src;
  assign ALUOp_IDEX    = q.alu_op;
  assign ForwardA      = q.fwd_a;
  assign ForwardB      = q.fwd_b;

`ifdef IDEX_PERF_CNT_EN
  logic        bubble_event;
  logic        fwd_event;
  logic [31:0] bubble_cnt;
  logic [31:0] fwd_cnt;

  // A flush under Hold still loads a bubble, but the pipeline is frozen, so that edge is not counted.
  assign bubble_event = ~Hold & (Flush_EX | Stall_ID);
  assign fwd_event    = load_id & ((sel_a != SEL_REG) | (sel_b != SEL_REG));

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
      fwd_cnt    <= '0;
    end else begin
      if (bubble_event && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
      if (fwd_event && fwd_cnt != '1)       fwd_cnt    <= fwd_cnt + 32'd1;
    end
  end

  assign BubbleCount = bubble_cnt;
  assign FwdCount    = fwd_cnt;
`else
  assign BubbleCount = '0;
  assign FwdCount    = '0;
`endif

endmodule

// File: tb/tb_idex_fwd_reg.sv
// Bench for idex_fwd_reg: directed vector table, hand-written reset/hold sequences, then random traffic
// checked against a reference model of the pipeline slot. Counter checks follow IDEX_PERF_CNT_EN.
module tb_idex_fwd_reg;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int OPW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, Valid_ID, UsesRs2_ID;
  logic [DW-1:0]  Reg1_ID, Reg2_ID, Imm_ID;
  logic [RW-1:0]  Rs1_ID, Rs2_ID, Rd_ID, Rd_EXM;
  logic           RegWrite_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID;
  logic [OPW-1:0] ALUOp_ID;
  logic           RegWrite_EXM, Flush_EX, Hold;
  logic [DW-1:0]  Reg1_IDEX, Reg2_IDEX, Imm_IDEX;
  logic [RW-1:0]  Rs1_IDEX, Rs2_IDEX, Rd_IDEX;
  logic           RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, ALUSrc_IDEX, Valid_IDEX;
  logic [OPW-1:0] ALUOp_IDEX;
  logic [1:0]     ForwardA, ForwardB;
  logic           Stall_ID;
  logic [31:0]    BubbleCount, FwdCount;

  idex_fwd_reg #(.DW(DW), .RW(RW), .OPW(OPW)) dut (
    .clk(clk), .reset(reset), .Valid_ID(Valid_ID),
    .Reg1_ID(Reg1_ID), .Reg2_ID(Reg2_ID), .Imm_ID(Imm_ID),
    .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .Rd_ID(Rd_ID), .UsesRs2_ID(UsesRs2_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
    .ALUSrc_ID(ALUSrc_ID), .ALUOp_ID(ALUOp_ID),
    .Rd_EXM(Rd_EXM), .RegWrite_EXM(RegWrite_EXM), .Flush_EX(Flush_EX), .Hold(Hold),
    .Reg1_IDEX(Reg1_IDEX), .Reg2_IDEX(Reg2_IDEX), .Imm_IDEX(Imm_IDEX),
    .Rs1_IDEX(Rs1_IDEX), .Rs2_IDEX(Rs2_IDEX), .Rd_IDEX(Rd_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX), .MemRead_IDEX(MemRead_IDEX), .MemWrite_IDEX(MemWrite_IDEX),
    .ALUSrc_IDEX(ALUSrc_IDEX), .Valid_IDEX(Valid_IDEX), .ALUOp_IDEX(ALUOp_IDEX),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall_ID(Stall_ID),
    .BubbleCount(BubbleCount), .FwdCount(FwdCount)
  );

  typedef struct packed {
    logic        reset, valid;
    logic [31:0] reg1, reg2, imm;
    logic [4:0]  rs1, rs2, rd, rd_exm;
    logic        u2, rw, mr, mw, alusrc;
    logic [3:0]  aluop;
    logic        rw_exm, flush, hold;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] reg1, reg2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, alusrc;
    logic [3:0]  aluop;
    logic [1:0]  fa, fb;
  } slot_t;

  typedef struct {
    in_t        stim;
    logic       stall;
    int         src;   // table row whose instruction sits in EX afterwards, -1 for a bubble
    logic [1:0] fa, fb;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  slot_t       m;
  logic [31:0] exp_bub, exp_fwd;
  vec_t        tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t s);
    reset = s.reset;  Valid_ID = s.valid;
    Reg1_ID = s.reg1; Reg2_ID = s.reg2; Imm_ID = s.imm;
    Rs1_ID = s.rs1;   Rs2_ID = s.rs2;   Rd_ID = s.rd;  UsesRs2_ID = s.u2;
    RegWrite_ID = s.rw; MemRead_ID = s.mr; MemWrite_ID = s.mw;
    ALUSrc_ID = s.alusrc; ALUOp_ID = s.aluop;
    Rd_EXM = s.rd_exm; RegWrite_EXM = s.rw_exm;
    Flush_EX = s.flush; Hold = s.hold;
  endtask

  function automatic slot_t capture(input in_t s, input logic [1:0] fa, input logic [1:0] fb);
    slot_t r;
    r.valid = 1'b1; r.reg1 = s.reg1; r.reg2 = s.reg2; r.imm = s.imm;
    r.rs1 = s.rs1; r.rs2 = s.rs2; r.rd = s.rd;
    r.rw = s.rw; r.mr = s.mr; r.mw = s.mw; r.alusrc = s.alusrc; r.aluop = s.aluop;
    r.fa = fa; r.fb = fb;
    return r;
  endfunction

  // Where operand x must come from once the consumer reaches EX: the youngest writer of x wins.
  function automatic logic [1:0] youngest(input logic [4:0] x, input slot_t ex, input in_t s);
    if (ex.valid && ex.rw && ex.rd != 0 && ex.rd == x && !ex.mr) return 2'b10;
    if (s.rw_exm && s.rd_exm != 0 && s.rd_exm == x) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_stall(input slot_t ex, input in_t s);
    logic needs;
    needs = (ex.rd == s.rs1) || (s.u2 && ex.rd == s.rs2);
    return !s.hold && s.valid && ex.valid && ex.mr && ex.rd != 0 && needs;
  endfunction

  task automatic model_step(input in_t s, input logic stall);
    logic [1:0] fa, fb;
    fa = youngest(s.rs1, m, s);
    fb = s.u2 ? youngest(s.rs2, m, s) : 2'b00;
    if (s.reset) begin
      m = '0; exp_bub = 0; exp_fwd = 0;
    end else if (s.flush) begin
      m = '0;
      if (!s.hold && exp_bub != 32'hFFFF_FFFF) exp_bub++;
    end else if (s.hold) begin
      m = m;
    end else if (stall) begin
      m = '0;
      if (exp_bub != 32'hFFFF_FFFF) exp_bub++;
    end else if (!s.valid) begin
      m = '0;
    end else begin
      m = capture(s, fa, fb);
      if ((fa != 0 || fb != 0) && exp_fwd != 32'hFFFF_FFFF) exp_fwd++;
    end
  endtask

  task automatic compare_state(input string tag);
    check({tag, " valid"},  {31'd0, Valid_IDEX},    {31'd0, m.valid});
    check({tag, " reg1"},   Reg1_IDEX,              m.reg1);
    check({tag, " reg2"},   Reg2_IDEX,              m.reg2);
    check({tag, " imm"},    Imm_IDEX,               m.imm);
    check({tag, " rs1"},    {27'd0, Rs1_IDEX},      {27'd0, m.rs1});
    check({tag, " rs2"},    {27'd0, Rs2_IDEX},      {27'd0, m.rs2});
    check({tag, " rd"},     {27'd0, Rd_IDEX},       {27'd0, m.rd});
    check({tag, " ctrl"},   {28'd0, RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, ALUSrc_IDEX},
                            {28'd0, m.rw, m.mr, m.mw, m.alusrc});
    check({tag, " aluop"},  {28'd0, ALUOp_IDEX},    {28'd0, m.aluop});
    check({tag, " fwd_a"},  {30'd0, ForwardA},      {30'd0, m.fa});
    check({tag, " fwd_b"},  {30'd0, ForwardB},      {30'd0, m.fb});
`ifdef IDEX_PERF_CNT_EN
    check({tag, " bubble_cnt"}, BubbleCount, exp_bub);
    check({tag, " fwd_cnt"},    FwdCount,    exp_fwd);
`else
    check({tag, " bubble_cnt"}, BubbleCount, 32'd0);
    check({tag, " fwd_cnt"},    FwdCount,    32'd0);
`endif
  endtask

  task automatic add(input logic v, input int rs1, input int rs2, input int rd, input logic u2,
                     input logic rw, input logic mr, input int rd_exm, input logic rw_exm,
                     input logic flush, input logic hold, input logic stall, input int src,
                     input logic [1:0] fa, input logic [1:0] fb);
    vec_t e;
    int   i;
    i = tbl.size();
    e.stim = '0;
    e.stim.valid = v;
    e.stim.reg1 = 32'h1100_0000 | i; e.stim.reg2 = 32'h2200_0000 | i; e.stim.imm = 32'h3300_0000 | i;
    e.stim.rs1 = rs1[4:0]; e.stim.rs2 = rs2[4:0]; e.stim.rd = rd[4:0]; e.stim.u2 = u2;
    e.stim.rw = rw; e.stim.mr = mr; e.stim.mw = (i % 7 == 3) && !mr;
    e.stim.alusrc = i[0]; e.stim.aluop = i[3:0];
    e.stim.rd_exm = rd_exm[4:0]; e.stim.rw_exm = rw_exm;
    e.stim.flush = flush; e.stim.hold = hold;
    e.stall = stall; e.src = src; e.fa = fa; e.fb = fb;
    tbl.push_back(e);
  endtask

  function automatic in_t rand_in();
    in_t s;
    s.reset = ($urandom_range(0, 49) == 0);
    s.valid = ($urandom_range(0, 3) != 0);
    s.reg1 = $urandom; s.reg2 = $urandom; s.imm = $urandom;
    s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
    s.rd = 5'($urandom_range(0, 3));  s.rd_exm = 5'($urandom_range(0, 3));
    s.u2 = 1'($urandom); s.rw = ($urandom_range(0, 3) != 0); s.mr = ($urandom_range(0, 2) == 0);
    s.mw = 1'($urandom); s.alusrc = 1'($urandom); s.aluop = 4'($urandom);
    s.rw_exm = 1'($urandom);
    s.flush = ($urandom_range(0, 7) == 0);
    s.hold  = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  initial begin
    in_t  s;
    logic st;

    //   v rs1 rs2 rd u2 rw mr exm wexm fl ho | stall src fa fb
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, -1, 2'b00, 2'b00);  // idle x3
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, -1, 2'b00, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, -1, 2'b00, 2'b00);
    add(1, 1, 2, 5, 1, 1, 0, 0, 0, 0, 0,  0,  3, 2'b00, 2'b00);  // ADD x5
    add(1, 6, 5, 8, 1, 1, 0, 0, 0, 0, 0,  0,  4, 2'b00, 2'b10);  // SUB rs2=x5
    add(1, 8, 8, 17, 1, 1, 0, 8, 1, 0, 0, 0,  5, 2'b10, 2'b10);  // EX beats EX/MEM
    add(1, 1, 2, 7, 1, 1, 0, 0, 0, 0, 0,  0,  6, 2'b00, 2'b00);  // producer x7
    add(1, 3, 4, 9, 1, 1, 0, 0, 0, 0, 0,  0,  7, 2'b00, 2'b00);  // gap
    add(1, 7, 10, 11, 1, 1, 0, 7, 1, 0, 0, 0, 8, 2'b01, 2'b00);  // consumer rs1=x7
    add(1, 1, 2, 0, 1, 1, 0, 0, 0, 0, 0,  0,  9, 2'b00, 2'b00);  // producer x0
    add(1, 0, 4, 12, 1, 1, 0, 0, 0, 0, 0, 0, 10, 2'b00, 2'b00);  // rs1=x0 vs EX rd=x0
    add(1, 0, 0, 13, 1, 1, 0, 0, 1, 0, 0, 0, 11, 2'b00, 2'b00);  // x0 vs EX/MEM rd=x0
    add(1, 20, 13, 14, 0, 1, 0, 0, 0, 0, 0, 0, 12, 2'b00, 2'b00); // rs2 unused
    add(1, 1, 2, 3, 0, 1, 1, 0, 0, 0, 0,  0, 13, 2'b00, 2'b00);  // LW x3
    add(1, 4, 3, 15, 1, 1, 0, 0, 0, 0, 0, 1, -1, 2'b00, 2'b00);  // load-use -> bubble
    add(1, 4, 3, 15, 1, 1, 0, 3, 1, 0, 0, 0, 15, 2'b00, 2'b01);  // retry via WB
    add(1, 15, 1, 18, 1, 1, 0, 0, 0, 1, 1, 0, -1, 2'b00, 2'b00); // flush beats hold
    add(1, 1, 2, 9, 0, 1, 1, 1, 1, 0, 0,  0, 17, 2'b01, 2'b00);  // LW x9
    add(1, 9, 2, 16, 0, 1, 0, 9, 1, 0, 1, 0, 17, 2'b01, 2'b00);  // hold, pending load-use
    add(1, 9, 2, 16, 0, 1, 0, 9, 1, 0, 1, 0, 17, 2'b01, 2'b00);
    add(1, 9, 2, 16, 0, 1, 0, 9, 1, 0, 0, 1, -1, 2'b00, 2'b00);  // hold released -> stall
    add(1, 1, 2, 20, 1, 1, 0, 0, 0, 0, 0, 0, 21, 2'b00, 2'b00);
    add(1, 20, 2, 21, 1, 1, 0, 0, 0, 1, 0, 0, -1, 2'b00, 2'b00); // flush alone

    s = '0;
    s.reset = 1'b1; s.valid = 1'b1; s.rd = 5'd4; s.rw = 1'b1;
    apply(s);
    m = '0; exp_bub = 0; exp_fwd = 0;
    repeat (2) @(posedge clk);
    #1 compare_state("reset");
    check("reset stall", {31'd0, Stall_ID}, 32'd0);

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i].stim);
      #1 check($sformatf("vec%0d stall", i), {31'd0, Stall_ID}, {31'd0, tbl[i].stall});
      @(posedge clk);
      #1;
      m = (tbl[i].src < 0) ? slot_t'('0) : capture(tbl[tbl[i].src].stim, tbl[i].fa, tbl[i].fb);
      if (!tbl[i].stim.hold && (tbl[i].stim.flush || tbl[i].stall)) exp_bub++;
      if (tbl[i].src == i && (tbl[i].fa != 0 || tbl[i].fb != 0)) exp_fwd++;
      compare_state($sformatf("vec%0d", i));
    end

    // Reset asserted in the very cycle a load-use stall is raised.
    s = '0; s.valid = 1'b1; s.rs1 = 5'd1; s.rd = 5'd3; s.rw = 1'b1; s.mr = 1'b1;
    s.reg2 = 32'hDEAD_BEEF;
    @(negedge clk); apply(s);
    @(posedge clk); #1;
    s.rs1 = 5'd3; s.rd = 5'd6; s.mr = 1'b0;
    @(negedge clk); apply(s);
    #1 check("pre-reset stall", {31'd0, Stall_ID}, 32'd1);
    s.reset = 1'b1; apply(s);
    @(posedge clk); #1;
    m = '0; exp_bub = 0; exp_fwd = 0;
    compare_state("reset mid-stall");
    check("reset mid-stall stall", {31'd0, Stall_ID}, 32'd0);

    // Reset together with Hold: the clear wins.
    s = '0; s.valid = 1'b1; s.rs1 = 5'd2; s.rd = 5'd5; s.rw = 1'b1; s.rd_exm = 5'd2; s.rw_exm = 1'b1;
    @(negedge clk); apply(s);
    @(posedge clk); #1;
    s.reset = 1'b1; s.hold = 1'b1;
    @(negedge clk); apply(s);
    @(posedge clk); #1;
    compare_state("reset mid-hold");

    for (int c = 0; c < 400; c++) begin
      s = rand_in();
      @(negedge clk);
      apply(s);
      st = model_stall(m, s);
      #1 check($sformatf("rnd%0d stall", c), {31'd0, Stall_ID}, {31'd0, st});
      @(posedge clk);
      #1;
      model_step(s, st);
      compare_state($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
